// File: rtl/seg_display.sv
// seg_display: time-multiplexed, active-low seven-segment driver with leading-zero
// blanking, sign placement, per-digit decimal points and frame-synchronous (tear-free) refresh.
module seg_display #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic                  clk,
  input  logic                  rst_ext,
  input  logic [4*N_DIGITS-1:0] value_bcd,
  input  logic                  value_vld,
  input  logic                  neg,
  input  logic                  blank_lz,
  input  logic [N_DIGITS-1:0]   dp,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [RW-1:0] RCNT_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] RCNT_ONE    = RW'(1);
  localparam logic [RW-1:0] GUARD_END   = RW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N_DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE     = IW'(1);
  localparam logic [IW:0]   IDX_ONE_X   = (IW+1)'(1);
  localparam logic [6:0]    GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0]    GLYPH_BLANK = 7'b1111111;

  logic [RW-1:0]           rcnt_r;
  logic [IW-1:0]           idx_r;
  logic [4*N_DIGITS-1:0]   shadow_bcd_r;
  logic                    shadow_neg_r;
  logic                    shadow_blz_r;
  logic [N_DIGITS-1:0]     shadow_dp_r;
  logic [4*N_DIGITS-1:0]   disp_bcd_r;
  logic                    disp_neg_r;
  logic                    disp_blz_r;
  logic [N_DIGITS-1:0]     disp_dp_r;

  logic                    rcnt_wrap_s;
  logic                    frame_wrap_s;
  logic                    guard_done_s;
  logic [IW-1:0]           msd_s;
  logic [3:0]              digit_s;
  logic                    lz_blank_s;
  logic                    minus_s;
  logic [6:0]              seg_s;
  logic                    dp_n_s;
  logic [N_DIGITS-1:0]     an_s;

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      4'hF:    g = 7'b0001110;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Index of the most significant nonzero digit; 0 when the whole value is zero.
  function automatic logic [IW-1:0] top_nonzero(input logic [4*N_DIGITS-1:0] bcd);
    logic [IW-1:0] m;
    m = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'h0) m = IW'(i);
    end
    return m;
  endfunction

  // Slot/frame timing decode and the next-cycle segment, anode and dp drive.
  always_comb begin
    rcnt_wrap_s  = (rcnt_r == RCNT_LAST);
    frame_wrap_s = rcnt_wrap_s && (idx_r == IDX_LAST);
    guard_done_s = (rcnt_r >= GUARD_END);
    digit_s      = disp_bcd_r[{idx_r, 2'b00} +: 4];
    msd_s        = top_nonzero(disp_bcd_r);
    lz_blank_s   = disp_blz_r && (idx_r > msd_s);
    minus_s      = disp_neg_r && disp_blz_r && (msd_s != IDX_LAST) &&
                   ({1'b0, idx_r} == ({1'b0, msd_s} + IDX_ONE_X));
    if (minus_s) begin
      seg_s = GLYPH_MINUS;
    end else if (lz_blank_s) begin
      seg_s = GLYPH_BLANK;
    end else begin
      seg_s = hex_glyph(digit_s);
    end
    dp_n_s = !disp_dp_r[idx_r];
    for (int i = 0; i < N_DIGITS; i++) begin
      an_s[i] = !(guard_done_s && (idx_r == IW'(i)));
    end
  end

  // Refresh counter and digit index.
  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      rcnt_r <= '0;
      idx_r  <= '0;
    end else if (rcnt_wrap_s) begin
      rcnt_r <= '0;
      idx_r  <= frame_wrap_s ? '0 : idx_r + IDX_ONE;
    end else begin
      rcnt_r <= rcnt_r + RCNT_ONE;
    end
  end

  // Shadow captures every strobe; the display copy only moves at the frame boundary.
  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      shadow_bcd_r <= '0;
      shadow_neg_r <= 1'b0;
      shadow_blz_r <= 1'b0;
      shadow_dp_r  <= '0;
      disp_bcd_r   <= '0;
      disp_neg_r   <= 1'b0;
      disp_blz_r   <= 1'b0;
      disp_dp_r    <= '0;
    end else begin
      if (value_vld) begin
        shadow_bcd_r <= value_bcd;
        shadow_neg_r <= neg;
        shadow_blz_r <= blank_lz;
        shadow_dp_r  <= dp;
      end
      if (frame_wrap_s) begin
        disp_bcd_r <= shadow_bcd_r;
        disp_neg_r <= shadow_neg_r;
        disp_blz_r <= shadow_blz_r;
        disp_dp_r  <= shadow_dp_r;
      end
    end
  end

  // Registered pin drive, one cycle behind the slot state.
  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      an         <= '1;
      seg        <= GLYPH_BLANK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_s;
      seg        <= seg_s;
      dp_n       <= dp_n_s;
      frame_done <= frame_wrap_s;
    end
  end

endmodule

// File: doc/seg_display.md
# seg_display

Time-multiplexed, active-low seven-segment display driver for the calculator's output path. It takes the calculator result as packed BCD digits plus a sign flag and scans them onto a common-anode display. Leading-zero blanking, sign placement, and per-digit decimal points are handled here, and the refresh is tear-free. It is the display-side counterpart of the button debounce inputs: the datapath result enters, and human-visible segment drive leaves.

## Interface
- `N_DIGITS`, 8: number of display digits; range 2..8.
- `REFRESH_DIV`, 100000: clock cycles per digit slot; must be greater than `GUARD`.
- `GUARD`, 16: cycles at the start of each slot with all anodes off, to prevent ghosting.
- `clk` in 1: system clock.
- `rst_ext` in 1: asynchronous, active-high reset.
- `value_bcd` in 4*N_DIGITS: packed digits; digit i is `value_bcd[4i+3:4i]`; digit 0 is rightmost.
- `value_vld` in 1: one-cycle load strobe for `value_bcd`, `neg`, `dp`, `blank_lz`.
- `neg` in 1: value is negative.
- `blank_lz` in 1: enable leading-zero blanking.
- `dp` in N_DIGITS: decimal point request per digit, active-high.
- `an` out N_DIGITS: anode enables, active-low, one-hot or all-off.
- `seg` out 7: cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp_n` out 1: decimal point cathode, active-low.
- `frame_done` out 1: one-cycle pulse at each frame wrap.

## Operation
- **Shadow register:** captures `value_bcd`, `neg`, `dp`, `blank_lz` on any cycle with `value_vld` = 1.
- **Display register:** loads from the shadow only at the frame boundary, so a frame never mixes old and new values.
- **Refresh counter:** `rcnt` counts 0..REFRESH_DIV-1 and wraps.
- **Digit index:** on `rcnt` wrap, `idx` increments modulo N_DIGITS. The frame boundary is `idx` wrapping N_DIGITS-1 → 0. In that cycle the display register loads and `frame_done` = 1.
- **Decoding:**
  - 0..9: standard glyphs.
  - 0xA..0xF: A, b, C, d, E, F.
  - Example patterns: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, 9 = 7'b0010000.
  - Minus glyph = 7'b0111111. Blank = 7'b1111111.
- **Leading-zero blanking** (`blank_lz` = 1):
  - m = highest index holding a nonzero digit; m = 0 if the value is all zero.
  - Digits above m are blank. Digit 0 is never blanked.
- **Sign:** when `neg` = 1, `blank_lz` = 1 and m < N_DIGITS-1, position m+1 shows minus. In every other case the sign is dropped, with no error.
- **Decimal point:** `dp_n` = ~dp[idx] for the displayed digit, including blanked or minus positions.
- **Guard window:** while `rcnt` < GUARD, `an` is all ones. Otherwise `an` = ~(1<<idx).

## Timing
- **Reset values:** `an` all ones, `seg` 7'h7F, `dp_n` 1, `frame_done` 0. `rcnt`, `idx`, shadow and display registers are all 0.
- **Registered outputs:** `an`, `seg`, `dp_n` and `frame_done` are registered, one cycle after the `rcnt`/`idx` state that selects them.
- **Start of a slot:** on the cycle after `rcnt` wraps, `an` goes all-off, and `seg`/`dp_n` switch to the new digit on that same edge. `an` asserts GUARD cycles later.
- **After reset release:**
  - First edge: slot 0 begins with `rcnt` = 0.
  - Edges 1..GUARD: `an` stays off.
  - Edge GUARD+1: `an` = ~1, showing display register digit 0 (reset value 0 decodes to "0").
- **Load latency:** a value strobed in frame k is displayed from the start of frame k+1.
  - If `value_vld` coincides with the boundary cycle, the display loads the pre-edge shadow. The new value then appears one frame later.
  - With multiple `value_vld` within one frame, the last one wins.
- **`frame_done`:** high exactly one cycle per N_DIGITS*REFRESH_DIV cycles. It is registered, so it is seen one cycle after the boundary.
- **Reset mid-frame:** outputs go to reset values immediately (async). Scanning restarts at slot 0 and the display content returns to 0.

## Test plan
Bench parameters: N_DIGITS=4, REFRESH_DIV=8, GUARD=2.

1. **Reset/first slot:** release reset.
   - `an`=4'hF for 3 edges.
   - Then `an`=4'b1110, `seg`=7'b1000000, `dp_n`=1 for 6 cycles.
   - `frame_done` pulses every 32 cycles.
2. **Tear-free load:** strobe `value_bcd`=16'h1234, `blank_lz`=0 mid-frame.
   - Current frame is unchanged.
   - Next frame: digits 0..3 show 4, 3, 2, 1; digit 3 `seg`=7'b1111001.
3. **Blanking and sign:** `value_bcd`=16'h0042, `neg`=1, `blank_lz`=1.
   - Digit 3 blank (7'h7F), digit 2 minus (7'b0111111), digits 1 and 0 show 4 and 2.
4. **Sign overflow and zero:**
   - 16'h9999 with `neg`=1: all four digits show 9, no minus.
   - 16'h0000 with `blank_lz`=1: only digit 0 shows "0".
5. **Boundary strobe and dp:** strobe 16'h0005 with `dp`=4'b0010 exactly in the boundary cycle.
   - The old value persists one more frame.
   - In the following frame, `dp_n`=0 only during slot 1.
6. **Async reset mid-slot 2:** assert `rst_ext` between edges.
   - `an`=4'hF and `seg`=7'h7F immediately.
   - After release, the sequence of scenario 1 repeats.
